// File: rtl/fsm_pkg.sv
// Shared definitions for example_fsm and its din_stager feeder.
// State bit indices, local stager encoding and a one-hot helper.
package fsm_pkg;

  localparam int FSM_STATE_W = 5;

  localparam int stIDLE      = 0;
  localparam int stPIPE1     = 1;
  localparam int stPIPE2     = 2;
  localparam int stLOAD_NEXT = 3;
  localparam int stLOAD_DOUT = 4;

  localparam logic [1:0] sIDLE  = 2'd0;
  localparam logic [1:0] sISSUE = 2'd1;
  localparam logic [1:0] sBUSY  = 2'd2;

  function automatic logic is_onehot(input logic [FSM_STATE_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/din_fifo.sv
// Synchronous FIFO holding {iters, data} entries for din_stager.
// Pointers wrap naturally because DEPTH is a power of two.
module din_fifo
  import fsm_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/din_stager.sv
// Feeds example_fsm one buffered word at a time and signals its final pass.
// Define DIN_STAGER_ONEHOT_CHK_EN to build the sticky one-hot state checker.
module din_stager
  import fsm_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ITER_W = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     s_valid,
  input  logic [DATA_W-1:0]        s_data,
  input  logic [ITER_W-1:0]        s_iters,
  output logic                     s_ready,
  output logic                     din_rdy,
  output logic [DATA_W-1:0]        din_data,
  output logic                     done,
  input  logic [FSM_STATE_W-1:0]   state,
  input  logic [FSM_STATE_W-1:0]   state_next,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     state_err
);

  logic [1:0]               stage;
  logic [ITER_W-1:0]        iters_eff;
  logic [ITER_W-1:0]        pass_cnt;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     issue;
  logic [DATA_W+ITER_W-1:0] head;
  logic [DATA_W-1:0]        head_data;
  logic [ITER_W-1:0]        head_iters;

  assign s_ready    = !full;
  assign push       = s_valid && s_ready;
  assign issue      = (stage == sIDLE) && !empty && state[stIDLE];
  assign head_data  = head[DATA_W-1:0];
  assign head_iters = head[DATA_W +: ITER_W];
  assign din_rdy    = (stage == sISSUE);

  din_fifo #(
    .WIDTH (DATA_W + ITER_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (issue),
    .wdata   ({s_iters, s_data}),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // done is registered from state_next so it lines up with the final stLOAD_NEXT
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stage     <= sIDLE;
      din_data  <= '0;
      iters_eff <= '0;
      pass_cnt  <= '0;
      done      <= 1'b0;
    end else begin
      done <= (stage == sBUSY) && state_next[stLOAD_NEXT] &&
              (pass_cnt == iters_eff - ITER_W'(1));
      case (stage)
        sIDLE: begin
          if (issue) begin
            stage     <= sISSUE;
            din_data  <= head_data;
            iters_eff <= (head_iters == '0) ? ITER_W'(1) : head_iters;
            pass_cnt  <= '0;
          end
        end
        sISSUE: begin
          stage <= sBUSY;
        end
        sBUSY: begin
          if (state[stLOAD_NEXT] && (pass_cnt != '1)) begin
            pass_cnt <= pass_cnt + ITER_W'(1);
          end
          if (state[stLOAD_DOUT]) begin
            stage <= sIDLE;
          end
        end
        default: begin
          stage <= sIDLE;
        end
      endcase
    end
  end

`ifdef DIN_STAGER_ONEHOT_CHK_EN
  logic unused_next;
  assign unused_next = ^{state_next[4], state_next[2:0]};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_err <= 1'b0;
    end else if (((stage == sISSUE) || (stage == sBUSY)) && !is_onehot(state)) begin
      state_err <= 1'b1;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{state_next[4], state_next[2:0], state[2:1]};
  assign state_err   = 1'b0;
`endif

endmodule

// File: tb/tb_din_stager.sv
// Bench for din_stager: emulates example_fsm and checks against a word-queue model.
// Expectation for state_err follows DIN_STAGER_ONEHOT_CHK_EN.
module tb_din_stager;
  import fsm_pkg::*;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;
  localparam int ITER_W  = 4;
  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic [ITER_W-1:0] s_iters;
  logic              s_ready;
  logic              din_rdy;
  logic [DATA_W-1:0] din_data;
  logic              done;
  logic [4:0]        state;
  logic [4:0]        state_next;
  logic [LEVEL_W-1:0] level;
  logic              state_err;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                iters;
  } word_t;

  word_t             q[$];
  logic [DATA_W-1:0] cur_data;
  int                cur_eff;
  int                visits;
  int                last_visits;
  int                issued;
  int                pushed;
  bit                active;
  bit                saw_full;
  logic              exp_err;

  din_stager #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ITER_W (ITER_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_iters    (s_iters),
    .s_ready    (s_ready),
    .din_rdy    (din_rdy),
    .din_data   (din_data),
    .done       (done),
    .state      (state),
    .state_next (state_next),
    .level      (level),
    .state_err  (state_err)
  );

  always #5 clock = ~clock;

  function automatic logic [4:0] oh(input int idx);
    logic [4:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Behaviour of example_fsm as seen by its feeder
  function automatic logic [4:0] next_of(input logic [4:0] st, input logic rdy, input logic dn);
    if (st[stIDLE])      return rdy ? oh(stPIPE1) : oh(stIDLE);
    if (st[stPIPE1])     return oh(stPIPE2);
    if (st[stPIPE2])     return oh(stLOAD_NEXT);
    if (st[stLOAD_NEXT]) return dn ? oh(stLOAD_DOUT) : oh(stPIPE1);
    return oh(stIDLE);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the environment: FIFO/word model plus FSM emulation
  task automatic step();
    logic [4:0] sn;
    logic [4:0] old_state;
    bit         acc;
    bit         rst;
    word_t      w;
    sn        = state_next;
    old_state = state;
    rst       = !reset_n;
    acc       = reset_n && s_valid && (q.size() < DEPTH);
    if (reset_n) begin
      check_output("s_ready", 32'(s_ready), 32'(q.size() < DEPTH));
      check_output("level", 32'(level), 32'(q.size()));
      if (s_valid && q.size() == DEPTH) saw_full = 1'b1;
    end
    @(posedge clock);
    #1;
    if (rst) begin
      q.delete();
      active = 1'b0;
      visits = 0;
      state  = oh(stIDLE);
    end else begin
      if (acc) begin
        w.data  = s_data;
        w.iters = int'(s_iters);
        q.push_back(w);
        pushed++;
      end
      state = sn;
      if (din_rdy) begin
        check_output("issue_while_idle", 32'(active), 32'(0));
        check_output("issue_fsm_idle", 32'(old_state[stIDLE]), 32'(1));
        check_output("issue_queue_nonempty", 32'(q.size() != 0), 32'(1));
        if (q.size() != 0) begin
          w = q.pop_front();
          check_output("issue_data", 32'(din_data), 32'(w.data));
          cur_data = w.data;
          cur_eff  = (w.iters == 0) ? 1 : w.iters;
          visits   = 0;
          active   = 1'b1;
          issued++;
        end
      end else if (active) begin
        check_output("din_data_hold", 32'(din_data), 32'(cur_data));
      end
      if (state[stLOAD_NEXT]) begin
        visits++;
        check_output("done_final_pass", 32'(done), 32'(active && visits == cur_eff));
      end else begin
        check_output("done_low", 32'(done), 32'(0));
      end
      if (state[stLOAD_DOUT]) begin
        check_output("pass_count", 32'(visits), 32'(cur_eff));
        last_visits = visits;
        active      = 1'b0;
      end
    end
    state_next = next_of(state, din_rdy, done);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    s_valid = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Leaves s_valid high so callers can stream words back to back
  task automatic push_word(input logic [DATA_W-1:0] d, input logic [ITER_W-1:0] it);
    int  n;
    bit  acc;
    s_valid = 1'b1;
    s_data  = d;
    s_iters = it;
    n       = 0;
    acc     = 1'b0;
    while (!acc && n < 200) begin
      acc = (q.size() < DEPTH);
      step();
      n++;
    end
    check_output("push_accept_timeout", 32'(acc), 32'(1));
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(q.size() == 0 && !active && state == oh(stIDLE) && !din_rdy) && n < budget) begin
      step();
      n++;
    end
    check_output({tag, "_idle_timeout"}, 32'(n < budget), 32'(1));
  endtask

  task automatic wait_state(input string tag, input int idx, input int qlen, input int budget);
    int n;
    n = 0;
    while (!(state[idx] && (qlen < 0 || q.size() == qlen)) && n < budget) begin
      step();
      n++;
    end
    check_output({tag, "_wait_timeout"}, 32'(n < budget), 32'(1));
  endtask

  initial begin
    int start_issued;
    int sent;
    int cyc;
    bit acc;
`ifdef DIN_STAGER_ONEHOT_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset_n     = 1'b0;
    s_valid     = 1'b0;
    s_data      = '0;
    s_iters     = '0;
    state       = oh(stIDLE);
    state_next  = oh(stIDLE);
    active      = 1'b0;
    visits      = 0;
    last_visits = 0;
    issued      = 0;
    pushed      = 0;
    saw_full    = 1'b0;
    cur_data    = '0;
    cur_eff     = 1;

    apply_reset();
    check_output("rst_s_ready", 32'(s_ready), 32'(1));
    check_output("rst_din_rdy", 32'(din_rdy), 32'(0));
    check_output("rst_done", 32'(done), 32'(0));
    check_output("rst_din_data", 32'(din_data), 32'(0));
    check_output("rst_level", 32'(level), 32'(0));
    check_output("rst_state_err", 32'(state_err), 32'(0));

    push_word(8'hA5, 4'd1);
    s_valid = 1'b0;
    check_output("lat_no_rdy_at_push", 32'(din_rdy), 32'(0));
    step();
    check_output("lat_rdy_after_pop", 32'(din_rdy), 32'(1));
    check_output("lat_din_data", 32'(din_data), 32'(8'hA5));
    step();
    check_output("lat_rdy_one_cycle", 32'(din_rdy), 32'(0));
    check_output("lat_fsm_pipe1", 32'(state), 32'(oh(stPIPE1)));
    run_until_idle("iters1", 100);
    check_output("iters1_passes", 32'(last_visits), 32'(1));

    push_word(8'h3C, 4'd3);
    s_valid = 1'b0;
    run_until_idle("iters3", 100);
    check_output("iters3_passes", 32'(last_visits), 32'(3));
    check_output("iters3_din_data", 32'(din_data), 32'(8'h3C));

    push_word(8'h5A, 4'd0);
    s_valid = 1'b0;
    run_until_idle("iters0", 100);
    check_output("iters0_passes", 32'(last_visits), 32'(1));

    start_issued = issued;
    saw_full     = 1'b0;
    push_word(8'h10, 4'd2);
    for (int i = 1; i <= DEPTH + 1; i++) begin
      push_word(8'(8'h10 + i), 4'd1);
    end
    s_valid = 1'b0;
    check_output("fill_stall_seen", 32'(saw_full), 32'(1));
    run_until_idle("fill", 400);
    check_output("fill_issue_count", 32'(issued - start_issued), 32'(DEPTH + 2));

    push_word(8'h21, 4'd2);
    push_word(8'h22, 4'd1);
    push_word(8'h23, 4'd1);
    s_valid = 1'b0;
    wait_state("midrst", stPIPE2, 2, 100);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_output("midrst_level", 32'(level), 32'(0));
    check_output("midrst_din_rdy", 32'(din_rdy), 32'(0));
    check_output("midrst_done", 32'(done), 32'(0));
    for (int i = 0; i < 8; i++) begin
      step();
      check_output("midrst_no_issue", 32'(din_rdy), 32'(0));
    end

    push_word(8'h77, 4'd2);
    s_valid = 1'b0;
    wait_state("onehot", stPIPE1, -1, 100);
    state = 5'b00110;
    step();
    check_output("onehot_err_set", 32'(state_err), 32'(exp_err));
    run_until_idle("onehot", 100);
    check_output("onehot_err_sticky", 32'(state_err), 32'(exp_err));
    apply_reset();
    check_output("onehot_err_cleared", 32'(state_err), 32'(0));

    sent = 0;
    cyc  = 0;
    while (sent < 40 && cyc < 6000) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = DATA_W'($urandom);
      s_iters = ITER_W'($urandom_range(0, 4));
      acc     = s_valid && (q.size() < DEPTH);
      step();
      if (acc) sent++;
      cyc++;
    end
    s_valid = 1'b0;
    check_output("rand_sent", 32'(sent), 32'(40));
    run_until_idle("rand", 1000);
    check_output("all_pushed_issued", 32'(issued), 32'(pushed - 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/din_stager.md
# din_stager

Upstream feeder for `example_fsm`. Buffers words from a producer in a small synchronous FIFO and issues one word at a time while the FSM is in stIDLE: it pulses `din_rdy` and holds `din_data`. It counts FSM passes through stLOAD_NEXT and asserts `done` so the FSM exits to stLOAD_DOUT after the requested number of iterations. It then waits for the FSM to return to stIDLE before issuing the next word.

## Interface
- `DATA_W`, default 8: data word width.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `ITER_W`, default 4: width of the per-word iteration count.
- `clock`  in  1: single clock; all logic on rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `s_valid`  in  1: producer word valid.
- `s_data`  in  `DATA_W`: producer word.
- `s_iters`  in  `ITER_W`: passes requested for this word; 0 is treated as 1.
- `s_ready`  out  1: FIFO can accept a word; equals !full.
- `din_rdy`  out  1: one-cycle issue pulse to the FSM.
- `din_data`  out  `DATA_W`: held word, stable from issue until the next issue.
- `done`  out  1: final-pass indication to the FSM.
- `state`  in  5: FSM one-hot current state.
- `state_next`  in  5: FSM one-hot next state.
- `level`  out  $clog2(DEPTH)+1: FIFO occupancy.
- `state_err`  out  1: sticky state-encoding error (see Configuration).

## Operation
- Local FSM states:
  - sIDLE → sISSUE when FIFO is not empty and `state[stIDLE]`=1. That cycle the block pops the FIFO, loads `din_data`, latches `iters_eff` = max(`s_iters`, 1) and clears `pass_cnt`.
  - sISSUE → sBUSY unconditionally; `din_rdy`=1 only while in sISSUE.
  - sBUSY → sIDLE on the cycle `state[stLOAD_DOUT]`=1.
- Pass counting:
  - In sBUSY, `pass_cnt` increments on each cycle `state[stLOAD_NEXT]`=1.
  - `pass_cnt` is `ITER_W` bits wide and saturates at all-ones.
- `done` register: `done` <= (sBUSY && `state_next[stLOAD_NEXT]` && `pass_cnt` == `iters_eff`-1). Otherwise `done` is 0. Result: a 1-cycle pulse coincident with the final stLOAD_NEXT.
- FIFO:
  - Push when `s_valid` && `s_ready`.
  - Pop only on the sIDLE→sISSUE transition.
  - Simultaneous push and pop leaves `level` unchanged.
  - Pointers wrap modulo `DEPTH`.
  - No push while full and no pop while empty; both are impossible by construction.
- `din_data` is never altered in sBUSY, even if the FIFO takes pushes.
- Issue is never attempted unless `state[stIDLE]`=1. A word waiting in sIDLE stays queued until the FSM reports stIDLE.

## Timing
- Reset values: `s_ready`=1, `din_rdy`=0, `done`=0, `din_data`=0, `level`=0, `state_err`=0. Local state is sIDLE, FIFO is empty, counters are 0.
- Reset mid-operation: the FIFO is flushed and any in-flight word is discarded. The FSM is reset by the same `reset_n`.
- Push to issue latency, FIFO empty and FSM idle:
  - Word pushed at edge N.
  - Pop at edge N+1.
  - `din_rdy` high between edges N+1 and N+2.
  - FSM shows stPIPE1 after edge N+2.
- Back-to-back words: minimum gap is stLOAD_DOUT → stIDLE (FSM), plus one cycle to detect stIDLE, plus the sISSUE cycle.
- `s_ready` is derived from registered `level`, so there is no combinational path from `s_valid`.
- `done` is fully registered, so there is no combinational path from `state`/`state_next`.

## Configuration
- Macro: `DIN_STAGER_ONEHOT_CHK_EN`.
- Defined: `state_err` sets and stays set until reset when, in sISSUE or sBUSY, `state` is not exactly one-hot. Operation otherwise continues unchanged.
- Undefined: `state_err` is tied to 0 and no check logic is built.

## Structure
- Shared package `fsm_pkg`:
  - State index localparams stIDLE=0, stPIPE1=1, stPIPE2=2, stLOAD_NEXT=3, stLOAD_DOUT=4.
  - `FSM_STATE_W`=5.
  - Local state encoding for sIDLE/sISSUE/sBUSY.
- Sub-module `din_fifo`: synchronous FIFO with parameters `DATA_W`+`ITER_W` and `DEPTH`, and outputs full/empty/level. The top level contains only control.

## Test plan
- Reset, then push {data=8'hA5, iters=1} with the FSM idle → `din_rdy` pulses 1 cycle; `din_data`=8'hA5; `done`=1 on the first stLOAD_NEXT; FSM reaches stLOAD_DOUT then stIDLE.
- Push iters=3 → stLOAD_NEXT is visited 3 times; `done` is high only on the 3rd visit; `din_data` is stable throughout.
- Push iters=0 → behaves exactly as iters=1.
- Push `DEPTH`+1 words with `s_valid` held high while the FSM is busy → `s_ready`=0 at `level`=4. The 5th word is accepted after the first pop. All words are issued in order, one per FSM cycle.
- Assert `reset_n`=0 during stPIPE2 with 2 words queued → next cycle `level`=0, `din_rdy`=0, `done`=0. No issue occurs after reset until a new push.
- With `DIN_STAGER_ONEHOT_CHK_EN`, force `state`=5'b00110 during sBUSY → `state_err`=1 and stays 1 until reset. Without the macro, `state_err` stays 0.
